// File: rtl/brew_sequencer.sv
// Grind/heat/pour sequencer with a small paid-order queue and resource fault parking.
// Optional STATS_EN macro adds cups_served / fault_count saturating counters.
module brew_sequencer #(
  parameter int GRIND_CYCLES  = 4,
  parameter int HEAT_CYCLES   = 8,
  parameter int POUR_CYCLES   = 6,
  parameter int WATER_PER_CUP = 2,
  parameter int MAX_PENDING   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       brew_req,
  input  logic       beans,
  input  logic [4:0] water,
  output logic       grinder_on,
  output logic       heater_on,
  output logic       pump_on,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       overflow,
  output logic [1:0] pending
`ifdef STATS_EN
  ,
  output logic [15:0] cups_served,
  output logic [7:0]  fault_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_GRIND, S_HEAT, S_POUR, S_DONE, S_FAULT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] pending_q, pending_d;
  logic       overflow_q, overflow_d;
  logic       water_ok;
  logic       accept;

  assign water_ok = (water >= 5'(WATER_PER_CUP));
  // A request landing in DONE is always taken: the finishing cup frees its slot.
  assign accept   = brew_req && ((pending_q != 2'(MAX_PENDING)) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: if (pending_q != 2'd0) state_d = S_CHECK;
      S_CHECK: begin
        if (beans && water_ok) begin
          state_d = S_GRIND;
          timer_d = 8'(GRIND_CYCLES - 1);
        end else begin
          state_d = S_FAULT;
        end
      end
      S_GRIND: begin
        if (!beans) begin
          state_d = S_FAULT;
          timer_d = 8'd0;
        end else if (timer_q == 8'd0) begin
          state_d = S_HEAT;
          timer_d = 8'(HEAT_CYCLES - 1);
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_HEAT: begin
        if (timer_q == 8'd0) begin
          state_d = S_POUR;
          timer_d = 8'(POUR_CYCLES - 1);
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_POUR: begin
        if (water == 5'd0) begin
          state_d = S_FAULT;
          timer_d = 8'd0;
        end else if (timer_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: if (beans && water_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    case ({accept, state_q == S_DONE})
      2'b10:   pending_d = pending_q + 2'd1;
      2'b01:   pending_d = pending_q - 2'd1;
      default: pending_d = pending_q;
    endcase
    overflow_d = brew_req && !accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= 8'd0;
      pending_q  <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign grinder_on = (state_q == S_GRIND);
  assign heater_on  = (state_q == S_HEAT);
  assign pump_on    = (state_q == S_POUR);
  assign busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign done       = (state_q == S_DONE);
  assign fault      = (state_q == S_FAULT);
  assign overflow   = overflow_q;
  assign pending    = pending_q;

`ifdef STATS_EN
  logic [15:0] cups_q;
  logic [7:0]  faults_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cups_q   <= 16'd0;
      faults_q <= 8'd0;
    end else begin
      if (state_q == S_DONE && cups_q != 16'hFFFF) cups_q <= cups_q + 16'd1;
      if (state_d == S_FAULT && state_q != S_FAULT && faults_q != 8'hFF)
        faults_q <= faults_q + 8'd1;
    end
  end

  assign cups_served = cups_q;
  assign fault_count = faults_q;
`endif

endmodule

// File: tb/tb_brew_sequencer.sv
// Scoreboard bench for brew_sequencer: expected done cycles are queued as orders are driven.
module tb_brew_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       brew_req;
  logic       beans;
  logic [4:0] water;
  logic       grinder_on, heater_on, pump_on, busy, done, fault, overflow;
  logic [1:0] pending;
`ifdef STATS_EN
  logic [15:0] cups_served;
  logic [7:0]  fault_count;
`endif

  brew_sequencer dut (
    .clk(clk), .rst(rst), .brew_req(brew_req), .beans(beans), .water(water),
    .grinder_on(grinder_on), .heater_on(heater_on), .pump_on(pump_on),
    .busy(busy), .done(done), .fault(fault), .overflow(overflow), .pending(pending)
`ifdef STATS_EN
    , .cups_served(cups_served), .fault_count(fault_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];
  int g_cnt = 0, h_cnt = 0, p_cnt = 0, ovf_cnt = 0, done_cnt = 0;
  int n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (grinder_on) g_cnt++;
    if (heater_on)  h_cnt++;
    if (pump_on)    p_cnt++;
    if (overflow)   ovf_cnt++;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) check_val("done_unexpected", 1, 0);
      else check_val("done_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    repeat (k) tick();
  endtask

  task automatic req();
    brew_req = 1'b1;
    tick();
    brew_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((pending !== 2'd0 || busy !== 1'b0) && t < 200) begin
      tick();
      t++;
    end
    check_val(tag, (t < 200), 1);
  endtask

  initial begin
    rst = 1'b1; brew_req = 1'b0; beans = 1'b1; water = 5'd10;
    ticks(2);
    check_val("reset_outputs",
              {grinder_on, heater_on, pump_on, busy, done, fault, overflow, pending}, 0);
    rst = 1'b0;
    tick();

    // single order, default latency
    g_cnt = 0; h_cnt = 0; p_cnt = 0; done_cnt = 0;
    req();
    exp_q.push_back(cyc + 20);
    check_val("t1_pending_after_req", pending, 1);
    tick();
    check_val("t1_busy_in_check", busy, 1);
    wait_idle("t1_finish");
    check_val("t1_grind_cycles", g_cnt, 4);
    check_val("t1_heat_cycles", h_cnt, 8);
    check_val("t1_pour_cycles", p_cnt, 6);
    check_val("t1_done_count", done_cnt, 1);
    check_val("t1_pending_end", pending, 0);

    // queue fill and overflow
    ovf_cnt = 0; done_cnt = 0;
    brew_req = 1'b1;
    tick();
    n = cyc;
    ticks(3);
    brew_req = 1'b0;
    exp_q.push_back(n + 20);
    exp_q.push_back(n + 41);
    exp_q.push_back(n + 62);
    check_val("t2_overflow_pulse", overflow, 1);
    check_val("t2_pending_full", pending, 3);
    tick();
    check_val("t2_overflow_clear", overflow, 0);
    wait_idle("t2_finish");
    check_val("t2_done_count", done_cnt, 3);
    check_val("t2_overflow_count", ovf_cnt, 1);

    // low water at CHECK, then recover
    water = 5'd1; done_cnt = 0;
    req();
    ticks(2);
    check_val("t3_fault", fault, 1);
    check_val("t3_pending_held", pending, 1);
    check_val("t3_busy_low", busy, 0);
    ticks(3);
    check_val("t3_fault_held", fault, 1);
    water = 5'd20;
    exp_q.push_back(cyc + 21);
    wait_idle("t3_finish");
    check_val("t3_done_count", done_cnt, 1);
    check_val("t3_fault_clear", fault, 0);

    // beans lost in the 2nd grind cycle
    water = 5'd10; done_cnt = 0; g_cnt = 0;
    req();
    ticks(3);
    check_val("t4_grinding", grinder_on, 1);
    beans = 1'b0;
    tick();
    check_val("t4_grinder_off", grinder_on, 0);
    check_val("t4_fault", fault, 1);
    check_val("t4_pending_held", pending, 1);
    check_val("t4_partial_grind", g_cnt, 2);
    g_cnt = 0;
    beans = 1'b1;
    exp_q.push_back(cyc + 21);
    wait_idle("t4_finish");
    check_val("t4_full_regrind", g_cnt, 4);
    check_val("t4_done_count", done_cnt, 1);

    // water runs dry in the 3rd pour cycle
    done_cnt = 0;
    req();
    ticks(16);
    check_val("t5_pouring", pump_on, 1);
    water = 5'd0;
    tick();
    check_val("t5_pump_off", pump_on, 0);
    check_val("t5_fault", fault, 1);
    check_val("t5_pending_held", pending, 1);
    p_cnt = 0;
    water = 5'd30;
    exp_q.push_back(cyc + 21);
    wait_idle("t5_finish");
    check_val("t5_full_pour", p_cnt, 6);
    check_val("t5_done_count", done_cnt, 1);

    // asynchronous reset during heat
    done_cnt = 0;
    req();
    req();
    ticks(7);
    check_val("t6_heating", heater_on, 1);
    check_val("t6_pending_two", pending, 2);
    #2 rst = 1'b1;
    #1;
    check_val("t6_heater_async_off", heater_on, 0);
    check_val("t6_pending_cleared", pending, 0);
    check_val("t6_busy_cleared", busy, 0);
    #3 rst = 1'b0;
    tick();
    ticks(60);
    check_val("t6_no_done", done_cnt, 0);
    check_val("t6_still_idle", {busy, fault, pending}, 0);

    check_val("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
